// File: rtl/analysis_pkg.sv
// Shared definitions for the FFT analysis chain: default sizes and the packed
// complex sample layout used on the FFT output stream.
package analysis_pkg;

  localparam int DEF_FFT_LEN = 1024;
  localparam int DEF_IN_W    = 16;
  localparam int DEF_OUT_W   = 48;
  localparam int BIN_W       = $clog2(DEF_FFT_LEN);

  // Square-and-add pipeline depth (register, square, sum).
  localparam int PIPE_STAGES = 3;

  // Complex sample as carried on the bus: re in the low half, im in the high half.
  typedef struct packed {
    logic signed [DEF_IN_W-1:0] im;
    logic signed [DEF_IN_W-1:0] re;
  } complex_sample_t;

endpackage

// File: rtl/axis_if.sv
// Minimal valid/ready stream interface.
interface Axis_If #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport Master (output valid, output data, input ready);
  modport Slave  (input valid, input data, output ready);
endinterface

// File: rtl/fft_mag_streamer_power_pipe.sv
// power_pipe: 3-stage |X|^2 datapath. Lane 0 is re, lane 1 is im. One shared
// enable freezes every stage; flush drops all valid bits. No handshake here.
module power_pipe
  import analysis_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_vld,
  input  logic [1:0][IN_W-1:0]  in_c,
  output logic                  out_vld,
  output logic [OUT_W-1:0]      pwr
);

  localparam int SQ_W = 2 * IN_W;

  logic [PIPE_STAGES:1]   vld_pipe;
  logic [1:0][IN_W-1:0]   s1_c;
  logic [1:0][SQ_W-1:0]   sq;
  logic [1:0][SQ_W-1:0]   s2_sq;
  logic [SQ_W:0]          s3_sum;

  // Per-lane square of the sign-extended component; the result is always
  // non-negative and at most 2^(2*IN_W-2), so it fits SQ_W bits unsigned.
  for (genvar g = 0; g < 2; g++) begin : g_lane
    logic signed [SQ_W-1:0] ext;
    assign ext   = SQ_W'(signed'(s1_c[g]));
    assign sq[g] = SQ_W'(ext * ext);
  end

  // Datapath registers: capture, square, sum. Held while en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_c   <= '0;
      s2_sq  <= '0;
      s3_sum <= '0;
    end else if (en) begin
      s1_c   <= in_c;
      s2_sq  <= sq;
      s3_sum <= {1'b0, s2_sq[0]} + {1'b0, s2_sq[1]};
    end
  end

  // Valid shift register; flush wins over a stall so resync always empties it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[PIPE_STAGES-1:1], in_vld};
    end
  end

  assign out_vld = vld_pipe[PIPE_STAGES];
  assign pwr     = OUT_W'(s3_sum);

endmodule

// File: rtl/fft_mag_streamer.sv
// fft_mag_streamer: complex FFT samples in, |X|^2 out, tagged with bin index and
// an end-of-frame pulse. Handles the global stall, bin counter and resync.
module fft_mag_streamer
  import analysis_pkg::*;
#(
  parameter int FFT_LEN = DEF_FFT_LEN,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  Axis_If.Slave                       din,
  Axis_If.Master                      dout,
  output logic [$clog2(FFT_LEN)-1:0]  bin_index,
  output logic                        frame_done,
  input  logic                        resync
);

  localparam int              CNT_W    = $clog2(FFT_LEN);
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FFT_LEN - 1);

  logic             rdy_en;
  logic             stall;
  logic             accept;
  logic             xfer;
  logic             pp_vld;
  logic [OUT_W-1:0] pp_pwr;
  logic [CNT_W-1:0] bin_cnt;
  logic [1:0][IN_W-1:0] in_c;

  // Input ready is held low during reset and for the edge that leaves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  assign stall     = pp_vld && !dout.ready;
  assign din.ready = rdy_en && !stall;
  assign accept    = din.valid && din.ready;
  assign in_c      = din.data[2*IN_W-1:0];

  power_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_power_pipe (
    .clk     (clk),
    .reset   (reset),
    .en      (!stall),
    .flush   (resync),
    .in_vld  (accept && !resync),
    .in_c    (in_c),
    .out_vld (pp_vld),
    .pwr     (pp_pwr)
  );

  assign dout.valid = pp_vld;
  assign dout.data  = pp_pwr;
  assign xfer       = pp_vld && dout.ready;

  // Bin counter: advances per output transfer, wraps per frame; resync wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_cnt <= '0;
    end else if (resync) begin
      bin_cnt <= '0;
    end else if (xfer) begin
      bin_cnt <= (bin_cnt == LAST_BIN) ? '0 : bin_cnt + 1'b1;
    end
  end

  assign bin_index  = bin_cnt;
  assign frame_done = xfer && !resync && (bin_cnt == LAST_BIN);

endmodule
